// File: rtl/counter_divider_pkg.sv
// Shared direction and mode encodings for the counter-divider.
// Latency: n/a (constants only).
// Backpressure: n/a.
package counter_divider_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic MODE_FREE = 1'b0;
    localparam logic MODE_DIV  = 1'b1;

endpackage

// File: rtl/param_counter_divider_if.sv
// Control and status bundle of the counter-divider; slave = counter side.
// Latency: n/a (wiring only).
// Backpressure: none; inputs are sampled on every clock edge.
interface param_counter_divider_if #(
    parameter int WIDTH = 8
);
    logic             load_n;
    logic             gn;
    logic             down_up;
    logic             mode;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic             max_min;
    logic             ripple_n;
    logic             tc_pulse;
    logic             div_sq;

    modport master (
        output load_n, gn, down_up, mode, din,
        input  q, max_min, ripple_n, tc_pulse, div_sq
    );

    modport slave (
        input  load_n, gn, down_up, mode, din,
        output q, max_min, ripple_n, tc_pulse, div_sq
    );
endinterface

// File: rtl/div_square_gen.sv
// Toggle flop turning terminal ticks into a 50 % duty square wave.
// Latency: output flips on the edge after a tick is seen.
// Backpressure: none.
module div_square_gen (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    output logic div_sq
);
    logic div_sq_q;
    logic div_sq_d;

    always_comb begin
        div_sq_d = div_sq_q ^ tick;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_sq_q <= 1'b0;
        end else begin
            div_sq_q <= div_sq_d;
        end
    end

    assign div_sq = div_sq_q;
endmodule

// File: rtl/param_counter_divider.sv
// Loadable up/down counter with auto-reload divider mode; square output under DIV_SQUARE_EN.
// Latency: load and count take 1 cycle; tc_pulse is registered alongside the post-terminal q.
// Backpressure: none; gn (active-low) stalls counting, load_n overrides it.
module param_counter_divider
    import counter_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    param_counter_divider_if.slave bus
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tc_pulse_q;
    logic             tc_pulse_d;
    logic             max_min;
    logic             terminal;

    // Terminal detect is combinational so a direction change is reflected before the next edge.
    assign max_min  = (bus.down_up == DIR_UP) ? (q_q == '1) : (q_q == '0);
    assign terminal = bus.load_n & ~bus.gn & max_min;

    always_comb begin
        q_d        = q_q;
        tc_pulse_d = 1'b0;
        if (!bus.load_n) begin
            q_d = bus.din;
        end else if (!bus.gn) begin
            if (max_min) begin
                tc_pulse_d = 1'b1;
                if (bus.mode == MODE_FREE) begin
                    q_d = (bus.down_up == DIR_DOWN) ? '1 : '0;
                end else begin
                    q_d = bus.din;
                end
            end else if (bus.down_up == DIR_DOWN) begin
                q_d = q_q - 1'b1;
            end else begin
                q_d = q_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q        <= '0;
            tc_pulse_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            tc_pulse_q <= tc_pulse_d;
        end
    end

`ifdef DIV_SQUARE_EN
    div_square_gen u_div_square_gen (
        .clk    (clk),
        .rst    (rst),
        .tick   (terminal),
        .div_sq (bus.div_sq)
    );
`else
    assign bus.div_sq = 1'b0;
`endif

    assign bus.q        = q_q;
    assign bus.max_min  = max_min;
    assign bus.ripple_n = ~(max_min & ~bus.gn);
    assign bus.tc_pulse = tc_pulse_q;
endmodule

// File: tb/tb_param_counter_divider.sv
// Directed bench for param_counter_divider at WIDTH = 8; div_sq expectation follows DIV_SQUARE_EN.
module tb_param_counter_divider;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic exp_sq;

`ifdef DIV_SQUARE_EN
    localparam bit SQ_EN = 1'b1;
`else
    localparam bit SQ_EN = 1'b0;
`endif

    param_counter_divider_if #(.WIDTH(8)) bus ();

    param_counter_divider #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks q, tc_pulse and div_sq together; toggles the expected square level on a pulse.
    task automatic chk_out(input string tag, input logic [7:0] eq, input logic etc);
        if (etc && SQ_EN) exp_sq = ~exp_sq;
        chk({tag, ".q"}, {24'h0, bus.q}, {24'h0, eq});
        chk({tag, ".tc"}, {31'h0, bus.tc_pulse}, {31'h0, etc});
        chk({tag, ".sq"}, {31'h0, bus.div_sq}, {31'h0, exp_sq});
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        exp_sq      = 1'b0;
        rst         = 1'b1;
        bus.load_n  = 1'b1;
        bus.gn      = 1'b1;
        bus.down_up = 1'b0;
        bus.mode    = 1'b0;
        bus.din     = 8'h00;
        #1 rst = 1'b0;
        #1;
        // Reset state
        chk_out("reset", 8'h00, 1'b0);
        chk("reset.max_min", {31'h0, bus.max_min}, 32'h0);
        chk("reset.ripple_n", {31'h0, bus.ripple_n}, 32'h1);
        bus.down_up = 1'b1;
        #1;
        chk("reset.max_min_down", {31'h0, bus.max_min}, 32'h1);
        chk("reset.ripple_n_gn1", {31'h0, bus.ripple_n}, 32'h1);
        bus.gn = 1'b0;
        #1;
        chk("reset.ripple_n_gn0", {31'h0, bus.ripple_n}, 32'h0);
        step();
        chk_out("reset.held", 8'h00, 1'b0);

        // Free-run up from FD across the wrap
        rst         = 1'b1;
        bus.down_up = 1'b0;
        bus.load_n  = 1'b0;
        bus.din     = 8'hFD;
        step();
        chk_out("free.load", 8'hFD, 1'b0);
        bus.load_n = 1'b1;
        step();
        chk_out("free.fe", 8'hFE, 1'b0);
        step();
        chk_out("free.ff", 8'hFF, 1'b0);
        chk("free.ff.max_min", {31'h0, bus.max_min}, 32'h1);
        chk("free.ff.ripple_n", {31'h0, bus.ripple_n}, 32'h0);
        step();
        chk_out("free.wrap", 8'h00, 1'b1);
        step();
        chk_out("free.01", 8'h01, 1'b0);

        // Enable held off
        bus.gn = 1'b1;
        step();
        chk_out("hold", 8'h01, 1'b0);
        step();
        chk_out("hold2", 8'h01, 1'b0);

        // Divider up, din = 8F: ratio 113
        bus.gn     = 1'b0;
        bus.mode   = 1'b1;
        bus.din    = 8'h8F;
        bus.load_n = 1'b0;
        step();
        chk_out("divup.load", 8'h8F, 1'b0);
        bus.load_n = 1'b1;
        for (int i = 1; i <= 112; i++) begin
            step();
            chk_out("divup.count", 8'(8'h8F + i), 1'b0);
        end
        step();
        chk_out("divup.reload1", 8'h8F, 1'b1);
        for (int i = 1; i <= 112; i++) begin
            step();
            chk_out("divup.count2", 8'(8'h8F + i), 1'b0);
        end
        // Load arrives on the terminal edge: load wins, no pulse, no toggle
        bus.load_n = 1'b0;
        bus.din    = 8'h10;
        step();
        chk_out("prio.load_at_tc", 8'h10, 1'b0);

        // Divider down, din = 03: ratio 4
        bus.load_n  = 1'b0;
        bus.down_up = 1'b1;
        bus.din     = 8'h03;
        step();
        chk_out("divdn.load", 8'h03, 1'b0);
        bus.load_n = 1'b1;
        for (int r = 0; r < 2; r++) begin
            step();
            chk_out("divdn.2", 8'h02, 1'b0);
            step();
            chk_out("divdn.1", 8'h01, 1'b0);
            step();
            chk_out("divdn.0", 8'h00, 1'b0);
            chk("divdn.0.max_min", {31'h0, bus.max_min}, 32'h1);
            step();
            chk_out("divdn.reload", 8'h03, 1'b1);
        end

        // Divider down, din = 00: ratio 1, pulse stays high
        bus.load_n = 1'b0;
        bus.din    = 8'h00;
        step();
        chk_out("ratio1.load", 8'h00, 1'b0);
        bus.load_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("ratio1.pulse", 8'h00, 1'b1);
        end

        // Mid-count reset at q = 40
        bus.down_up = 1'b0;
        bus.mode    = 1'b0;
        bus.load_n  = 1'b0;
        bus.din     = 8'h40;
        step();
        chk_out("mid.load", 8'h40, 1'b0);
        #2 rst = 1'b0;
        #1;
        exp_sq = 1'b0;
        chk_out("mid.reset", 8'h00, 1'b0);
        bus.mode   = 1'b1;
        bus.din    = 8'hF0;
        bus.load_n = 1'b1;
        bus.gn     = 1'b0;
        #1 rst = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            step();
            chk_out("mid.count", 8'(i), 1'b0);
        end
        step();
        chk_out("mid.first_pulse", 8'hF0, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk_out("mid.count2", 8'(8'hF0 + i), 1'b0);
        end
        step();
        chk_out("mid.second_pulse", 8'hF0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
